// File: rtl/issue_select.sv
`default_nettype none

`ifndef N
`define N 2
`endif
`ifndef RS_SZ
`define RS_SZ 8
`endif
`ifndef B_MASK_W
`define B_MASK_W 4
`endif

// ============================================================================
//  Package : issue_select_pkg
//  Brief   : Reservation-station packet layout shared by the issue selector
//            and its users.
//  Rev     : 1.0 - initial release
// ============================================================================
package issue_select_pkg;
  localparam int B_MASK_W  = `B_MASK_W;
  localparam int PAYLOAD_W = 8;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;        // opaque op contents / tag
    logic [B_MASK_W-1:0]  b_mask;         // unresolved branches this op depends on
    logic                 is_mult;        // needs the shared multiplier
    logic                 Source1_ready;
    logic                 Source2_ready;
  } RS_PACKET;
endpackage

// ============================================================================
//  Module  : issue_select
//  Brief   : Picks up to N ready reservation-station entries per cycle
//            (lowest index first), limits the single non-pipelined
//            multiplier to one op per MULT_LAT cycles, and registers the
//            chosen packets toward the functional units. Held packets keep
//            tracking branch resolution and are squashed on mispredict.
//  Ports   :
//    clock            in   clock for all state
//    reset            in   asynchronous active-high reset
//    rs_data          in   full station contents, RS_SZ packets
//    rs_valid_next    in   per-entry valid (already squash-filtered)
//    rs_data_issuing  out  combinational: entries granted this cycle
//    ex_stall         in   execute cannot accept; hold output registers
//    issue_packets    out  registered packets, slot k = k-th grant
//    issue_valid      out  registered valid per slot
//    b_mm_resolve     in   branch bit(s) resolving this cycle
//    b_mm_mispred     in   the resolving branch mispredicted
//  Rev     : 1.0 - initial release
// ============================================================================
module issue_select
  import issue_select_pkg::*;
#(
  parameter int N        = `N,
  parameter int RS_SZ    = `RS_SZ,
  parameter int MULT_LAT = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  RS_PACKET [RS_SZ-1:0]   rs_data,
  input  logic     [RS_SZ-1:0]   rs_valid_next,
  output logic     [RS_SZ-1:0]   rs_data_issuing,
  input  logic                   ex_stall,
  output RS_PACKET [N-1:0]       issue_packets,
  output logic     [N-1:0]       issue_valid,
  input  logic     [B_MASK_W-1:0] b_mm_resolve,
  input  logic                   b_mm_mispred
);

  localparam int CW = $clog2(MULT_LAT + 1);
  localparam int SW = $clog2(N + 1);

  RS_PACKET [N-1:0]     r_pkts;
  logic     [N-1:0]     r_vld;
  logic     [CW-1:0]    r_mult_busy_cnt;

  logic     [RS_SZ-1:0] w_ready;
  logic     [RS_SZ-1:0] w_issuing;
  RS_PACKET [N-1:0]     w_slot_pkt;
  logic     [N-1:0]     w_slot_vld;
  logic     [SW-1:0]    w_cnt;
  logic                 w_mult_grant;
  logic                 w_mult_ok;
  RS_PACKET [N-1:0]     w_pkt_nxt;
  logic     [N-1:0]     w_vld_nxt;

  // An entry is ready when both operands are available and it does not
  // depend on the branch being resolved as mispredicted right now.
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < RS_SZ; i++) begin
      w_ready[i] = rs_valid_next[i] & rs_data[i].Source1_ready &
                   rs_data[i].Source2_ready &
                   ~(b_mm_mispred & (|(b_mm_resolve & rs_data[i].b_mask)));
    end
  end

  // The counter is loaded with MULT_LAT on the grant edge and the
  // multiplier accepts again in the cycle where it reads 1 (its last busy
  // cycle), so consecutive mult grants are exactly MULT_LAT cycles apart.
  assign w_mult_ok = (r_mult_busy_cnt <= CW'(1));

  // Priority scan: lowest index first, packing grants into slots 0,1,...
  // A mult that cannot be taken is skipped without blocking later entries.
  always_comb begin
    w_issuing    = '0;
    w_slot_pkt   = '0;
    w_slot_vld   = '0;
    w_cnt        = '0;
    w_mult_grant = 1'b0;
    for (int i = 0; i < RS_SZ; i++) begin
      if (!ex_stall && !reset && w_ready[i] && (w_cnt < SW'(N))) begin
        if (!rs_data[i].is_mult || (w_mult_ok && !w_mult_grant)) begin
          w_issuing[i] = 1'b1;
          for (int k = 0; k < N; k++) begin
            if (w_cnt == SW'(k)) begin
              w_slot_pkt[k] = rs_data[i];
              w_slot_vld[k] = 1'b1;
            end
          end
          if (rs_data[i].is_mult) begin
            w_mult_grant = 1'b1;
          end
          w_cnt = w_cnt + SW'(1);
        end
      end
    end
  end

  // Next output-register contents. Held slots still drop resolved branch
  // bits and are killed on mispredict; fresh grants were already filtered
  // by w_ready, so only their masks need the resolve bits cleared.
  always_comb begin
    w_pkt_nxt = '0;
    w_vld_nxt = '0;
    for (int k = 0; k < N; k++) begin
      if (ex_stall) begin
        w_pkt_nxt[k]        = r_pkts[k];
        w_pkt_nxt[k].b_mask = r_pkts[k].b_mask & ~b_mm_resolve;
        w_vld_nxt[k]        = r_vld[k] &
                              ~(b_mm_mispred & (|(r_pkts[k].b_mask & b_mm_resolve)));
      end else begin
        w_pkt_nxt[k]        = w_slot_pkt[k];
        w_pkt_nxt[k].b_mask = w_slot_pkt[k].b_mask & ~b_mm_resolve;
        w_vld_nxt[k]        = w_slot_vld[k];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pkts          <= '0;
      r_vld           <= '0;
      r_mult_busy_cnt <= '0;
    end else begin
      r_pkts <= w_pkt_nxt;
      r_vld  <= w_vld_nxt;
      // A squashed mult still occupies the multiplier, so the counter is
      // never cleared by branch recovery.
      if (w_mult_grant) begin
        r_mult_busy_cnt <= CW'(MULT_LAT);
      end else if (r_mult_busy_cnt != '0) begin
        r_mult_busy_cnt <= r_mult_busy_cnt - CW'(1);
      end
    end
  end

  assign rs_data_issuing = w_issuing;
  assign issue_packets   = r_pkts;
  assign issue_valid     = r_vld;

endmodule

`default_nettype wire

// File: tb/tb_issue_select.sv
`default_nettype none

// ============================================================================
//  Module  : tb_issue_select
//  Brief   : Directed vector table plus hand sequences for issue_select
//            (N=2, RS_SZ=8, MULT_LAT=4).
//  Rev     : 1.0 - initial release
// ============================================================================
module tb_issue_select;
  import issue_select_pkg::*;

  localparam int N  = 2;
  localparam int RS = 8;
  localparam int ML = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  RS_PACKET [RS-1:0]    rs_data;
  logic     [RS-1:0]    rs_valid_next;
  logic     [RS-1:0]    rs_data_issuing;
  logic                 ex_stall;
  RS_PACKET [N-1:0]     issue_packets;
  logic     [N-1:0]     issue_valid;
  logic     [B_MASK_W-1:0] b_mm_resolve;
  logic                 b_mm_mispred;

  int checks = 0;
  int errors = 0;

  issue_select #(.N(N), .RS_SZ(RS), .MULT_LAT(ML)) dut (
    .clock          (clock),
    .reset          (reset),
    .rs_data        (rs_data),
    .rs_valid_next  (rs_valid_next),
    .rs_data_issuing(rs_data_issuing),
    .ex_stall       (ex_stall),
    .issue_packets  (issue_packets),
    .issue_valid    (issue_valid),
    .b_mm_resolve   (b_mm_resolve),
    .b_mm_mispred   (b_mm_mispred)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Entry i carries payload i; b_mask is 0100 where sel4 is set, 0010 where
  // sel2 is set, otherwise 0001.
  task automatic set_rs(input logic [7:0] vld, input logic [7:0] s1, input logic [7:0] s2,
                        input logic [7:0] mult, input logic [7:0] sel4, input logic [7:0] sel2);
    for (int i = 0; i < RS; i++) begin
      rs_data[i].payload       = 8'(i);
      rs_data[i].b_mask        = sel4[i] ? 4'b0100 : (sel2[i] ? 4'b0010 : 4'b0001);
      rs_data[i].is_mult       = mult[i];
      rs_data[i].Source1_ready = s1[i];
      rs_data[i].Source2_ready = s2[i];
    end
    rs_valid_next = vld;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0] vld, s1, s2, mult, sel4;
    logic [3:0] res;
    logic       mis;
    logic [7:0] iss;
    logic [1:0] ev;
    logic [7:0] p0, p1;
    logic [3:0] m0;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // vld    s1     s2     mult   sel4   res  mis   iss    ev     p0 p1 m0
    tbl[0] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 2'b00, 8'd0, 8'd0, 4'h0};
    tbl[1] = '{8'h4A, 8'hFF, 8'hFF, 8'h00, 8'h00, 4'h0, 1'b0, 8'h0A, 2'b11, 8'd1, 8'd3, 4'h1};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 4'h0, 1'b0, 8'h03, 2'b11, 8'd0, 8'd1, 4'h1};
    tbl[3] = '{8'h80, 8'hFF, 8'hFF, 8'h00, 8'h00, 4'h0, 1'b0, 8'h80, 2'b01, 8'd7, 8'd0, 4'h1};
    tbl[4] = '{8'hFF, 8'hFF, 8'hF0, 8'h00, 8'h00, 4'h0, 1'b0, 8'h30, 2'b11, 8'd4, 8'd5, 4'h1};
    tbl[5] = '{8'h15, 8'hFF, 8'hFF, 8'h05, 8'h00, 4'h0, 1'b0, 8'h11, 2'b11, 8'd0, 8'd4, 4'h1};
    tbl[6] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h03, 4'h4, 1'b1, 8'h0C, 2'b11, 8'd2, 8'd3, 4'h1};
    tbl[7] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h03, 4'h4, 1'b0, 8'h03, 2'b11, 8'd0, 8'd1, 4'h0};
    tbl[8] = '{8'h07, 8'hFF, 8'hFF, 8'h03, 8'h00, 4'h0, 1'b0, 8'h05, 2'b11, 8'd0, 8'd2, 4'h1};
    tbl[9] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 4'h0, 1'b0, 8'h00, 2'b00, 8'd0, 8'd0, 4'h0};

    reset        = 1'b1;
    ex_stall     = 1'b0;
    b_mm_resolve = '0;
    b_mm_mispred = 1'b0;
    set_rs(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
    #2;
    chk("rst_valid",   32'(issue_valid), 32'h0);
    chk("rst_packets", 32'(issue_packets), 32'h0);
    chk("rst_issuing", 32'(rs_data_issuing), 32'h0);
    tick();
    reset = 1'b0;

    // ---------------- table vectors ----------------
    for (int v = 0; v < 10; v++) begin
      do_reset();
      set_rs(tbl[v].vld, tbl[v].s1, tbl[v].s2, tbl[v].mult, tbl[v].sel4, 8'h00);
      b_mm_resolve = tbl[v].res;
      b_mm_mispred = tbl[v].mis;
      #1;
      chk($sformatf("v%0d_issuing", v), 32'(rs_data_issuing), 32'(tbl[v].iss));
      tick();
      b_mm_resolve = '0;
      b_mm_mispred = 1'b0;
      chk($sformatf("v%0d_valid", v), 32'(issue_valid), 32'(tbl[v].ev));
      if (tbl[v].ev[0]) begin
        chk($sformatf("v%0d_slot0", v), 32'(issue_packets[0].payload), 32'(tbl[v].p0));
        chk($sformatf("v%0d_mask0", v), 32'(issue_packets[0].b_mask), 32'(tbl[v].m0));
      end
      if (tbl[v].ev[1]) begin
        chk($sformatf("v%0d_slot1", v), 32'(issue_packets[1].payload), 32'(tbl[v].p1));
      end
    end

    // ---------------- multiplier spacing ----------------
    do_reset();
    set_rs(8'h15, 8'hFF, 8'hFF, 8'h05, 8'h00, 8'h00);
    #1;
    chk("mul_first", 32'(rs_data_issuing), 32'h11);
    tick();
    set_rs(8'h04, 8'hFF, 8'hFF, 8'h05, 8'h00, 8'h00);
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("mul_busy_c%0d", c), 32'(rs_data_issuing), 32'h0);
      tick();
    end
    #1;
    chk("mul_c4", 32'(rs_data_issuing), 32'h04);
    tick();
    chk("mul_c4_valid", 32'(issue_valid), 32'h1);
    chk("mul_c4_slot0", 32'(issue_packets[0].payload), 32'd2);

    // ---------------- stall / branch resolution ----------------
    do_reset();
    set_rs(8'h0A, 8'hFF, 8'hFF, 8'h00, 8'h08, 8'h02);
    #1;
    chk("stl_issuing", 32'(rs_data_issuing), 32'h0A);
    tick();
    chk("stl_load_valid", 32'(issue_valid), 32'h3);
    chk("stl_load_p0", 32'(issue_packets[0].payload), 32'd1);
    chk("stl_load_p1", 32'(issue_packets[1].payload), 32'd3);
    ex_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stl_iss_c%0d", c), 32'(rs_data_issuing), 32'h0);
      tick();
      chk($sformatf("stl_hold_v_c%0d", c), 32'(issue_valid), 32'h3);
      chk($sformatf("stl_hold_p1_c%0d", c), 32'(issue_packets[1].payload), 32'd3);
    end
    b_mm_resolve = 4'b0100;
    b_mm_mispred = 1'b0;
    tick();
    chk("res_ok_valid", 32'(issue_valid), 32'h3);
    chk("res_ok_mask1", 32'(issue_packets[1].b_mask), 32'h0);
    chk("res_ok_mask0", 32'(issue_packets[0].b_mask), 32'h2);
    b_mm_resolve = '0;
    ex_stall     = 1'b0;
    #1;
    chk("unstall_iss", 32'(rs_data_issuing), 32'h0A);
    tick();
    chk("unstall_valid", 32'(issue_valid), 32'h3);
    chk("unstall_mask1", 32'(issue_packets[1].b_mask), 32'h4);
    ex_stall     = 1'b1;
    b_mm_resolve = 4'b0100;
    b_mm_mispred = 1'b1;
    #1;
    chk("mis_iss", 32'(rs_data_issuing), 32'h0);
    tick();
    chk("mis_valid", 32'(issue_valid), 32'h1);
    chk("mis_mask0", 32'(issue_packets[0].b_mask), 32'h2);
    b_mm_resolve = '0;
    b_mm_mispred = 1'b0;
    ex_stall     = 1'b0;
    set_rs(8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
    #1;
    chk("empty_iss", 32'(rs_data_issuing), 32'h0);
    tick();
    chk("empty_valid", 32'(issue_valid), 32'h0);

    // ---------------- async reset mid-multiply ----------------
    do_reset();
    set_rs(8'h01, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00);
    #1;
    chk("ar_mul_iss", 32'(rs_data_issuing), 32'h01);
    tick();
    set_rs(8'h02, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
    #1;
    chk("ar_add_iss", 32'(rs_data_issuing), 32'h02);
    tick();
    chk("ar_pre_valid", 32'(issue_valid), 32'h1);
    set_rs(8'h01, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00);
    #1;
    chk("ar_mul_blocked", 32'(rs_data_issuing), 32'h0);
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(issue_valid), 32'h0);
    chk("ar_packets", 32'(issue_packets), 32'h0);
    chk("ar_issuing", 32'(rs_data_issuing), 32'h0);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_post_iss", 32'(rs_data_issuing), 32'h01);
    tick();
    chk("ar_post_valid", 32'(issue_valid), 32'h1);
    chk("ar_post_p0", 32'(issue_packets[0].payload), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
